// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// Advances one raster position per i_pix_stb. Level outputs are registered
// decodes of the next counter values, so they always describe the current
// position. Event strobes are combinational, gated by i_pix_stb and masked
// by reset.
//
// Ports:
//   i_clk        base clock
//   i_rst        synchronous active-high reset, restarts the frame at (0,0)
//   i_pix_stb    pixel strobe, one raster step per clock with strobe high
//   o_hs/o_vs    horizontal/vertical sync at configured polarity
//   o_hblank     horizontal blanking
//   o_vblank     vertical blanking
//   o_active     visible pixel
//   o_x/o_y      visible position, clamped to the active area
//   o_line_end   pulse on the last strobe of every line
//   o_animate    pulse on the last strobe of the last active line
//   o_frame_end  pulse on the last strobe of the frame
//   o_frame_cnt  completed frames since reset, wraps
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 10,
  parameter int unsigned FW       = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_stb,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_hblank,
  output logic          o_vblank,
  output logic          o_active,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_end,
  output logic          o_animate,
  output logic          o_frame_end,
  output logic [FW-1:0] o_frame_cnt
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          hblank_q, hblank_d, vblank_q, vblank_d, active_q, active_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          line_end, animate, frame_end;
  // Decodes compare in 32 bits so a sync end equal to 2^CW stays correct.
  logic [31:0]   h_dx, v_dx;

  // Next-state counters, strobes and next-position level decode.
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    frame_d   = frame_q;
    line_end  = i_pix_stb && (h_q == CW'(H_TOTAL - 1));
    animate   = line_end && (v_q == CW'(V_ACTIVE - 1));
    frame_end = line_end && (v_q == CW'(V_TOTAL - 1));

    if (i_pix_stb) begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
    if (frame_end) frame_d = frame_q + FW'(1);

    h_dx     = 32'(h_d);
    v_dx     = 32'(v_d);
    hs_d     = (h_dx >= H_SYNC_LO && h_dx < H_SYNC_HI) ? H_POL : ~H_POL;
    vs_d     = (v_dx >= V_SYNC_LO && v_dx < V_SYNC_HI) ? V_POL : ~V_POL;
    hblank_d = (h_dx >= H_ACTIVE);
    vblank_d = (v_dx >= V_ACTIVE);
    active_d = ~(hblank_d | vblank_d);
    x_d      = hblank_d ? CW'(H_ACTIVE - 1) : h_d;
    y_d      = vblank_d ? CW'(V_ACTIVE - 1) : v_d;
  end

  // State and registered level outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q      <= '0;
      v_q      <= '0;
      frame_q  <= '0;
      hs_q     <= ~H_POL;
      vs_q     <= ~V_POL;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      active_q <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      frame_q  <= frame_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_hblank    = hblank_q;
  assign o_vblank    = vblank_q;
  assign o_active    = active_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_frame_cnt = frame_q;
  // Reset wins over a coincident strobe.
  assign o_line_end  = line_end  & ~i_rst;
  assign o_animate   = animate   & ~i_rst;
  assign o_frame_end = frame_end & ~i_rst;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance and a tiny-raster instance
// (H 4/1/2/1, V 3/1/1/1, positive sync, FW=2) share clock, reset and strobe.
// A position model per instance supplies expected values every clock.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic stb;

  logic       b_hs, b_vs, b_hblank, b_vblank, b_active, b_le, b_an, b_fe;
  logic [9:0] b_x, b_y;
  logic [15:0] b_fcnt;

  logic       s_hs, s_vs, s_hblank, s_vblank, s_active, s_le, s_an, s_fe;
  logic [9:0] s_x, s_y;
  logic [1:0] s_fcnt;

  always #5 clk = ~clk;

  vga_timing_gen u_big (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(b_hs), .o_vs(b_vs), .o_hblank(b_hblank), .o_vblank(b_vblank),
    .o_active(b_active), .o_x(b_x), .o_y(b_y),
    .o_line_end(b_le), .o_animate(b_an), .o_frame_end(b_fe),
    .o_frame_cnt(b_fcnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(10), .FW(2)
  ) u_small (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(s_hs), .o_vs(s_vs), .o_hblank(s_hblank), .o_vblank(s_vblank),
    .o_active(s_active), .o_x(s_x), .o_y(s_y),
    .o_line_end(s_le), .o_animate(s_an), .o_frame_end(s_fe),
    .o_frame_cnt(s_fcnt)
  );

  int checks = 0;
  int errors = 0;

  // Model positions and frame counts.
  int bh = 0, bv = 0, bf = 0;
  int sh = 0, sv = 0, sf = 0;

  // Aggregate event tallies.
  int b_le_n = 0, b_hs_low_n = 0;
  int s_le_n = 0, s_fe_n = 0, s_an_n = 0, s_act_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_levels();
    chk("big_hs",     32'(b_hs),     32'((bh >= 656 && bh <= 751) ? 0 : 1));
    chk("big_vs",     32'(b_vs),     32'((bv >= 490 && bv <= 491) ? 0 : 1));
    chk("big_hblank", 32'(b_hblank), 32'(bh >= 640));
    chk("big_vblank", 32'(b_vblank), 32'(bv >= 480));
    chk("big_active", 32'(b_active), 32'(bh < 640 && bv < 480));
    chk("big_x",      32'(b_x),      32'((bh > 639) ? 639 : bh));
    chk("big_y",      32'(b_y),      32'((bv > 479) ? 479 : bv));
    chk("big_fcnt",   32'(b_fcnt),   32'(bf));
    chk("small_hs",     32'(s_hs),     32'(sh == 5 || sh == 6));
    chk("small_vs",     32'(s_vs),     32'(sv == 4));
    chk("small_hblank", 32'(s_hblank), 32'(sh >= 4));
    chk("small_vblank", 32'(s_vblank), 32'(sv >= 3));
    chk("small_active", 32'(s_active), 32'(sh < 4 && sv < 3));
    chk("small_x",      32'(s_x),      32'((sh > 3) ? 3 : sh));
    chk("small_y",      32'(s_y),      32'((sv > 2) ? 2 : sv));
    chk("small_fcnt",   32'(s_fcnt),   32'(sf));
  endtask

  // One clock: drive inputs, check strobes before the edge, levels after.
  task automatic tick(input logic p_stb, input logic p_rst);
    logic adv, e_ble, e_bfe, e_sle, e_sfe;
    stb = p_stb;
    rst = p_rst;
    #1;
    adv   = p_stb && !p_rst;
    e_ble = adv && bh == 799;
    e_bfe = e_ble && bv == 524;
    e_sle = adv && sh == 7;
    e_sfe = e_sle && sv == 5;
    chk("big_line_end",    32'(b_le), 32'(e_ble));
    chk("big_animate",     32'(b_an), 32'(e_ble && bv == 479));
    chk("big_frame_end",   32'(b_fe), 32'(e_bfe));
    chk("small_line_end",  32'(s_le), 32'(e_sle));
    chk("small_animate",   32'(s_an), 32'(e_sle && sv == 2));
    chk("small_frame_end", 32'(s_fe), 32'(e_sfe));
    if (b_le === 1'b1) b_le_n++;
    if (s_le === 1'b1) s_le_n++;
    if (s_fe === 1'b1) s_fe_n++;
    if (s_an === 1'b1) s_an_n++;
    @(posedge clk);
    if (p_rst) begin
      bh = 0; bv = 0; bf = 0;
      sh = 0; sv = 0; sf = 0;
    end else if (p_stb) begin
      if (e_bfe) bf = (bf + 1) % 65536;
      if (e_ble) begin bh = 0; bv = (bv == 524) ? 0 : bv + 1; end
      else bh = bh + 1;
      if (e_sfe) sf = (sf + 1) % 4;
      if (e_sle) begin sh = 0; sv = (sv == 5) ? 0 : sv + 1; end
      else sh = sh + 1;
    end
    #1;
    check_levels();
    if (p_stb && b_hs === 1'b0) b_hs_low_n++;
  endtask

  initial begin
    stb = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset state.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);

    // Continuous strobe: five tiny frames, active count over the first.
    for (int i = 0; i < 240; i++) begin
      tick(1'b1, 1'b0);
      if (i < 48 && s_active === 1'b1) s_act_n++;
    end
    chk("small_active_per_frame", 32'(s_act_n), 32'd12);
    chk("small_line_ends_5f",     32'(s_le_n),  32'd30);
    chk("small_frame_ends_5f",    32'(s_fe_n),  32'd5);
    chk("small_animates_5f",      32'(s_an_n),  32'd5);
    chk("small_fcnt_wrap",        32'(s_fcnt),  32'd1);

    // Strobe every fourth clock until the big raster is into line 2.
    for (int i = 0; i < 1600; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
    end
    chk("big_line_ends",   32'(b_le_n),     32'd2);
    chk("big_hs_low_strb", 32'(b_hs_low_n), 32'd192);
    chk("big_x_mid",       32'(b_x),        32'd240);
    chk("big_y_mid",       32'(b_y),        32'd2);

    // Strobe held low: everything holds, no strobes.
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
    chk("big_x_hold", 32'(b_x), 32'd240);

    // Reset together with a strobe, mid-frame.
    s_fe_n = 0;
    tick(1'b1, 1'b1);
    chk("rst_big_x",     32'(b_x),    32'd0);
    chk("rst_big_y",     32'(b_y),    32'd0);
    chk("rst_small_fc",  32'(s_fcnt), 32'd0);

    // Following frame completes normally.
    for (int i = 0; i < 48; i++) tick(1'b1, 1'b0);
    chk("post_rst_frame_end", 32'(s_fe_n), 32'd1);
    chk("post_rst_fcnt",      32'(s_fcnt), 32'd1);
    chk("post_rst_big_x",     32'(b_x),    32'd48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
